sevenseg_bcd_display: RTL and testbench

SEVENSEG_BCD_DISPLAY -- requirements
Module: sevenseg_bcd_display

---
 rtl/sevenseg_pkg.sv | 27 ++
 rtl/seg_digit_decode.sv | 19 +
 rtl/sevenseg_bcd_display.sv | 139 +++++++++++++
 tb/tb_sevenseg_bcd_display.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and glyph constants for the BCD seven-segment display block.
// Glyph bit order is bit0=a .. bit6=g, active-high (1 = segment lit).
package sevenseg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  // Entry k is the glyph for decimal digit k (leftmost entry is 9).
  localparam logic [9:0][6:0] SEG_GLYPH = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// One digit of BCD-to-glyph decode; dash wins over blank, non-decimal codes go dark.
module seg_digit_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash)
      seg = SEG_DASH;
    else if (!blank && bcd <= 4'd9)
      seg = SEG_GLYPH[bcd];
  end

endmodule

// File: rtl/sevenseg_bcd_display.sv
// Binary-to-BCD (serial double-dabble, one bit per cycle) feeding a multi-digit
// seven-segment driver with leading-zero blanking and overflow dashes.
module sevenseg_bcd_display
  import sevenseg_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int DIGITS     = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      value,
  input  logic                  blank_lz,
  output logic [DIGITS*7-1:0]   data,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  out_valid,
  output logic                  overflow
);

  localparam int               CW       = $clog2(WIDTH + 1);
  localparam int               BW       = DIGITS * 4;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [63:0]      LIMIT    = pow10(DIGITS);
  localparam logic [6:0]       POL      = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS*7-1:0] DATA_RST = {DIGITS{SEG_BLANK ^ POL}};

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     sh_q, sh_d;
  logic [BW-1:0]        sr_q, sr_d, sr_adj;
  logic                 blank_q, blank_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic [BW-1:0]        bcd_q, bcd_d;
  logic [DIGITS*7-1:0]  data_q, data_d, seg_dec;
  logic                 ovf_q, ovf_d;
  logic                 vld_q, vld_d;
  logic [DIGITS-1:0]    dig_blank;

  assign in_ready  = (state_q == IDLE);
  assign data      = data_q;
  assign bcd       = bcd_q;
  assign overflow  = ovf_q;
  assign out_valid = vld_q;

  // Double-dabble correction: any nibble >= 5 would exceed 9 after the shift.
  always_comb begin
    sr_adj = sr_q;
    for (int k = 0; k < DIGITS; k++)
      if (sr_q[4*k +: 4] >= 4'd5) sr_adj[4*k +: 4] = sr_q[4*k +: 4] + 4'd3;
  end

  // A digit blanks when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic nz;
    nz        = 1'b0;
    dig_blank = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz           = nz | (sr_q[4*k +: 4] != 4'd0);
      dig_blank[k] = blank_q && !nz && (k != 0);
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    seg_digit_decode u_dec (
      .bcd   (sr_q[4*k +: 4]),
      .blank (dig_blank[k]),
      .dash  (ovf_acc_q),
      .seg   (seg_dec[7*k +: 7])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    sr_d      = sr_q;
    blank_d   = blank_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    vld_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d      = value;
          blank_d   = blank_lz;
          ovf_acc_d = (64'(value) >= LIMIT);
          sr_d      = '0;
          cnt_d     = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        sr_d  = {sr_adj[BW-2:0], sh_q[WIDTH-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = LOAD;
      end
      LOAD: begin
        bcd_d   = ovf_acc_q ? {BW{1'b1}} : sr_q;
        data_d  = seg_dec ^ {DIGITS{POL}};
        ovf_d   = ovf_acc_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      sr_q      <= '0;
      blank_q   <= 1'b0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      data_q    <= DATA_RST;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      sr_q      <= sr_d;
      blank_q   <= blank_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
    end
  end

endmodule

// File: tb/tb_sevenseg_bcd_display.sv
// Scoreboard bench: three display instances (6b/2d, 8b/2d, 32b/8d) checked against a
// decimal-arithmetic reference model; monitors pop expectations on out_valid.
module tb_sevenseg_bcd_display;

  typedef struct {
    logic [31:0] bcd;
    logic [55:0] data;
    logic        ovf;
    int          acc;
  } exp_t;

  localparam int W [3] = '{6, 8, 32};
  localparam int D [3] = '{2, 2, 8};

  logic        clk = 1'b0;
  logic        rst [3];
  logic        iv  [3];
  logic [31:0] val [3];
  logic        bl  [3];
  logic        rdy [3];
  logic        ov  [3];
  logic        ovf [3];
  logic [13:0] data0, data1;
  logic [55:0] data2;
  logic [7:0]  bcd0, bcd1;
  logic [31:0] bcd2;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  exp_t q0[$], q1[$], q2[$];
  logic [55:0] lastd [3];
  logic [31:0] lastb [3];
  logic        lasto [3];
  string GLY [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sevenseg_bcd_display #(.WIDTH(6), .DIGITS(2), .ACTIVE_LOW(1)) u_d0 (
    .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .value(val[0][5:0]), .blank_lz(bl[0]), .data(data0), .bcd(bcd0),
    .out_valid(ov[0]), .overflow(ovf[0]));
  sevenseg_bcd_display #(.WIDTH(8), .DIGITS(2), .ACTIVE_LOW(1)) u_d1 (
    .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .value(val[1][7:0]), .blank_lz(bl[1]), .data(data1), .bcd(bcd1),
    .out_valid(ov[1]), .overflow(ovf[1]));
  sevenseg_bcd_display #(.WIDTH(32), .DIGITS(8), .ACTIVE_LOW(1)) u_d2 (
    .clk(clk), .reset(rst[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
    .value(val[2]), .blank_lz(bl[2]), .data(data2), .bcd(bcd2),
    .out_valid(ov[2]), .overflow(ovf[2]));

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(string s);
    logic [6:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  // Reference: decimal digits by division, blanking by magnitude, active-low output.
  function automatic exp_t model(longint unsigned v, bit b, int digits);
    exp_t e;
    longint unsigned lim = 1, pk = 1;
    int d;
    logic [6:0] seg;
    e.bcd = '0; e.data = '0; e.acc = 0;
    for (int k = 0; k < digits; k++) lim = lim * 10;
    e.ovf = (v >= lim);
    for (int k = 0; k < digits; k++) begin
      d = int'((v / pk) % 10);
      if (e.ovf) begin
        e.bcd[4*k +: 4] = 4'hF;
        seg = seg_of("g");
      end else begin
        e.bcd[4*k +: 4] = 4'(d);
        seg = (b && k > 0 && v < pk) ? 7'h00 : seg_of(GLY[d]);
      end
      e.data[7*k +: 7] = ~seg;
      pk = pk * 10;
    end
    return e;
  endfunction

  function automatic logic [55:0] rst_data(int w);
    logic [63:0] t = (64'd1 << (7 * D[w])) - 64'd1;
    return t[55:0];
  endfunction

  function automatic int qsize(int w);
    case (w)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic mon(int w, logic v, logic [55:0] d, logic [31:0] b, logic o);
    exp_t e;
    if (rst[w]) begin
      lastd[w] = rst_data(w); lastb[w] = '0; lasto[w] = 1'b0;
      return;
    end
    if (v) begin
      chk($sformatf("d%0d expected result pending", w), 64'(qsize(w) > 0), 1);
      if (qsize(w) == 0) return;
      case (w)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("d%0d bcd", w), b, e.bcd);
      chk($sformatf("d%0d data", w), d, e.data);
      chk($sformatf("d%0d overflow", w), o, e.ovf);
      chk($sformatf("d%0d latency", w), cyc - e.acc - 1, W[w] + 1);
      lastd[w] = d; lastb[w] = b; lasto[w] = o;
    end else begin
      chk($sformatf("d%0d hold data", w), d, lastd[w]);
      chk($sformatf("d%0d hold bcd", w), b, lastb[w]);
      chk($sformatf("d%0d hold overflow", w), o, lasto[w]);
    end
  endtask

  always @(negedge clk) mon(0, ov[0], 56'(data0), 32'(bcd0), ovf[0]);
  always @(negedge clk) mon(1, ov[1], 56'(data1), 32'(bcd1), ovf[1]);
  always @(negedge clk) mon(2, ov[2], data2, bcd2, ovf[2]);

  task automatic push(int w, exp_t e);
    case (w)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(int w, logic [31:0] v, bit b);
    int n = 0;
    longint unsigned vm = longint'(v) & ((64'd1 << W[w]) - 64'd1);
    exp_t e;
    iv[w] = 1'b1; val[w] = v; bl[w] = b;
    while (!rdy[w] && n < 200) begin @(posedge clk); #1; n++; end
    chk($sformatf("d%0d accept within bound", w), rdy[w], 1);
    if (rdy[w]) begin
      e = model(vm, b, D[w]);
      e.acc = cyc;
      push(w, e);
      @(posedge clk); #1;
    end
    iv[w] = 1'b0;
  endtask

  task automatic wait_idle(int w);
    int n = 0;
    while (qsize(w) != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk($sformatf("d%0d drained within bound", w), 64'(qsize(w)), 0);
  endtask

  initial begin
    int last;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; iv[i] = 1'b0; val[i] = '0; bl[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    chk("reset in_ready", rdy[0], 1);
    chk("reset data", data0, 14'h3FFF);
    chk("reset bcd", bcd0, 0);
    chk("reset overflow", ovf[0], 0);
    chk("reset out_valid", ov[0], 0);

    send(0, 42, 0); wait_idle(0);
    chk("42 bcd", bcd0, 8'h42);
    chk("42 data", data0, {7'b0011001, 7'b0100100});
    send(0, 7, 1); wait_idle(0);
    chk("7 blank bcd", bcd0, 8'h07);
    chk("7 blank data", data0, {7'b1111111, 7'b1111000});
    send(0, 0, 1); wait_idle(0);
    chk("0 blank data", data0, {7'b1111111, 7'b1000000});
    send(0, 0, 0); send(0, 63, 1); send(0, 10, 1); wait_idle(0);

    send(1, 100, 0); wait_idle(1);
    chk("100 overflow", ovf[1], 1);
    chk("100 bcd", bcd1, 8'hFF);
    chk("100 data", data1, {7'b0111111, 7'b0111111});
    send(1, 99, 1); wait_idle(1);
    chk("99 overflow", ovf[1], 0);
    chk("99 bcd", bcd1, 8'h99);
    send(1, 255, 1); send(1, 5, 1); wait_idle(1);

    send(2, 99999999, 0); wait_idle(2);
    chk("99999999 bcd", bcd2, 32'h99999999);
    send(2, 100000000, 0); wait_idle(2);
    chk("100000000 overflow", ovf[2], 1);
    send(2, 1200, 1); send(2, 32'hFFFF_FFFF, 1); wait_idle(2);

    for (int i = 0; i < 20; i++) send(0, $urandom_range(0, 63), 1'($urandom % 2));
    for (int i = 0; i < 20; i++) send(1, $urandom_range(0, 255), 1'($urandom % 2));
    for (int i = 0; i < 8; i++) send(2, $urandom_range(0, 150000000), 1'($urandom % 2));
    wait_idle(0); wait_idle(1); wait_idle(2);

    // in_valid held high, value changing every cycle.
    last = -1;
    for (int i = 0; i < 50; i++) begin
      exp_t e;
      iv[0] = 1'b1; val[0] = $urandom_range(0, 63); bl[0] = 1'($urandom % 2);
      if (rdy[0]) begin
        if (last >= 0) chk("accept spacing", cyc - last, 8);
        last = cyc;
        e = model(val[0], bl[0], 2);
        e.acc = cyc;
        push(0, e);
      end
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    wait_idle(0);

    // Reset in the middle of a conversion.
    send(0, 50, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    q0.delete();
    repeat (2) begin @(posedge clk); #1; end
    rst[0] = 1'b0;
    chk("abort in_ready", rdy[0], 1);
    chk("abort data", data0, 14'h3FFF);
    chk("abort bcd", bcd0, 0);
    chk("abort overflow", ovf[0], 0);
    repeat (10) begin @(posedge clk); #1; end
    send(0, 63, 0); wait_idle(0);
    chk("post-reset 63 bcd", bcd0, 8'h63);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
